// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline boundary: captures ALU result and controls, resolves B/CBZ with a
// one-cycle redirect, and decouples EX from MEM through a 2-entry skid buffer.
module ex_mem_stage #(
  parameter int unsigned dataWidth    = 64,
  parameter int unsigned regAddrWidth = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [dataWidth-1:0]    alu_result,
  input  logic                    alu_zero,
  input  logic [dataWidth-1:0]    store_data,
  input  logic [regAddrWidth-1:0] rd,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic                    reg_write,
  input  logic                    mem_to_reg,
  input  logic                    branch,
  input  logic                    uncond_branch,
  input  logic [dataWidth-1:0]    branch_target,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [dataWidth-1:0]    out_result,
  output logic [dataWidth-1:0]    out_store_data,
  output logic [regAddrWidth-1:0] out_rd,
  output logic                    out_mem_read,
  output logic                    out_mem_write,
  output logic                    out_reg_write,
  output logic                    out_mem_to_reg,
  output logic                    out_zero,
  output logic                    redirect,
  output logic [dataWidth-1:0]    redirect_pc
);

  typedef struct packed {
    logic [dataWidth-1:0]    result;
    logic [dataWidth-1:0]    store_data;
    logic [regAddrWidth-1:0] rd;
    logic                    mem_read;
    logic                    mem_write;
    logic                    reg_write;
    logic                    mem_to_reg;
    logic                    zero;
  } payload_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e               state_q, state_d;
  payload_t             out_q, out_d;
  payload_t             skid_q, skid_d;
  payload_t             in_pl_c;
  logic                 out_valid_q, in_ready_q;
  logic                 redirect_q, redirect_d;
  logic [dataWidth-1:0] redirect_pc_q, redirect_pc_d;
  logic                 accept_c, is_br_c, taken_c, store_c, pop_c;

  assign in_pl_c = '{result: alu_result, store_data: store_data, rd: rd,
                     mem_read: mem_read, mem_write: mem_write, reg_write: reg_write,
                     mem_to_reg: mem_to_reg, zero: alu_zero};

  // The cycle carrying a redirect squashes the wrong-path instruction at the input.
  assign accept_c = in_valid && in_ready_q && !redirect_q;
  assign is_br_c  = branch || uncond_branch;
  assign taken_c  = uncond_branch || (branch && alu_zero);
  assign store_c  = accept_c && !is_br_c;
  assign pop_c    = out_valid_q && out_ready;

  // Occupancy, payload movement and branch resolution.
  always_comb begin
    state_d       = state_q;
    out_d         = out_q;
    skid_d        = skid_q;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;

    if (accept_c && is_br_c && taken_c) begin
      redirect_d    = 1'b1;
      redirect_pc_d = branch_target;
    end

    case (state_q)
      EMPTY: begin
        if (store_c) begin
          out_d   = in_pl_c;
          state_d = ONE;
        end
      end
      ONE: begin
        if (store_c && !pop_c) begin
          skid_d  = in_pl_c;
          state_d = TWO;
        end else if (store_c && pop_c) begin
          out_d   = in_pl_c;
        end else if (pop_c) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop_c) begin
          out_d   = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= EMPTY;
      out_q         <= '0;
      skid_q        <= '0;
      out_valid_q   <= 1'b0;
      in_ready_q    <= 1'b1;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      out_q         <= out_d;
      skid_q        <= skid_d;
      out_valid_q   <= (state_d != EMPTY);
      in_ready_q    <= (state_d != TWO);
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign in_ready       = in_ready_q;
  assign out_valid      = out_valid_q;
  assign out_result     = out_q.result;
  assign out_store_data = out_q.store_data;
  assign out_rd         = out_q.rd;
  assign out_mem_read   = out_q.mem_read;
  assign out_mem_write  = out_q.mem_write;
  assign out_reg_write  = out_q.reg_write;
  assign out_mem_to_reg = out_q.mem_to_reg;
  assign out_zero       = out_q.zero;
  assign redirect       = redirect_q;
  assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: streaming, backpressure, branches, squash, reset, STUR.
module tb_ex_mem_stage;

  localparam int unsigned DW = 64;
  localparam int unsigned RW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [DW-1:0] alu_result, store_data, branch_target;
  logic          alu_zero;
  logic [RW-1:0] rd;
  logic          mem_read, mem_write, reg_write, mem_to_reg, branch, uncond_branch;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_result, out_store_data, redirect_pc;
  logic [RW-1:0] out_rd;
  logic          out_mem_read, out_mem_write, out_reg_write, out_mem_to_reg, out_zero;
  logic          redirect;

  int checks = 0;
  int errors = 0;

  ex_mem_stage #(.dataWidth(DW), .regAddrWidth(RW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .alu_zero(alu_zero), .store_data(store_data), .rd(rd),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .branch(branch), .uncond_branch(uncond_branch), .branch_target(branch_target),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_store_data(out_store_data), .out_rd(out_rd),
    .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .out_reg_write(out_reg_write), .out_mem_to_reg(out_mem_to_reg), .out_zero(out_zero),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    in_valid = 1'b0; alu_result = '0; alu_zero = 1'b0; store_data = '0; rd = '0;
    mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b0; mem_to_reg = 1'b0;
    branch = 1'b0; uncond_branch = 1'b0; branch_target = '0;
  endtask

  task automatic send_alu(input logic [DW-1:0] res);
    idle_in();
    in_valid = 1'b1; alu_result = res; reg_write = 1'b1; rd = RW'(res);
  endtask

  task automatic send_br(input logic b, input logic ub, input logic z, input logic [DW-1:0] tgt);
    idle_in();
    in_valid = 1'b1; branch = b; uncond_branch = ub; alu_zero = z; branch_target = tgt;
  endtask

  initial begin
    idle_in();
    out_ready = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check("rst_out_valid", DW'(out_valid), 64'd0);
    check("rst_in_ready", DW'(in_ready), 64'd1);
    check("rst_redirect", DW'(redirect), 64'd0);
    check("rst_redirect_pc", redirect_pc, 64'd0);
    check("rst_out_result", out_result, 64'd0);

    // Stream 1..4 at full rate
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      send_alu(DW'(i));
      tick();
      check("stream_valid", DW'(out_valid), 64'd1);
      check("stream_result", out_result, DW'(i));
      check("stream_rd", DW'(out_rd), DW'(i));
      check("stream_in_ready", DW'(in_ready), 64'd1);
    end
    idle_in();
    tick();
    check("stream_drain_valid", DW'(out_valid), 64'd0);

    // Backpressure: A, B fill both entries, C held upstream
    out_ready = 1'b0;
    send_alu(64'hA); tick();
    check("bp_a_valid", DW'(out_valid), 64'd1);
    check("bp_a_result", out_result, 64'hA);
    check("bp_a_in_ready", DW'(in_ready), 64'd1);
    send_alu(64'hB); tick();
    check("bp_b_in_ready", DW'(in_ready), 64'd0);
    check("bp_b_hold", out_result, 64'hA);
    send_alu(64'hC); tick();
    check("bp_c_in_ready", DW'(in_ready), 64'd0);
    check("bp_c_hold", out_result, 64'hA);
    out_ready = 1'b1; tick();
    check("bp_rel_b", out_result, 64'hB);
    check("bp_rel_in_ready", DW'(in_ready), 64'd1);
    tick();
    check("bp_rel_c", out_result, 64'hC);
    check("bp_rel_c_valid", DW'(out_valid), 64'd1);
    idle_in(); tick();
    check("bp_drain_valid", DW'(out_valid), 64'd0);

    // CBZ taken, then wrong-path 0x99 must be squashed
    send_br(1'b1, 1'b0, 1'b1, 64'h40); alu_result = 64'h55; tick();
    check("cbz_t_redirect", DW'(redirect), 64'd1);
    check("cbz_t_pc", redirect_pc, 64'h40);
    check("cbz_t_no_store", DW'(out_valid), 64'd0);
    send_alu(64'h99); tick();
    check("cbz_t_pulse_end", DW'(redirect), 64'd0);
    check("cbz_t_squash", DW'(out_valid), 64'd0);
    idle_in(); tick();
    check("cbz_t_squash2", DW'(out_valid), 64'd0);

    // CBZ not taken, then B
    send_br(1'b1, 1'b0, 1'b0, 64'h60); tick();
    check("cbz_nt_redirect", DW'(redirect), 64'd0);
    check("cbz_nt_no_store", DW'(out_valid), 64'd0);
    send_br(1'b0, 1'b1, 1'b0, 64'h80); tick();
    check("b_redirect", DW'(redirect), 64'd1);
    check("b_pc", redirect_pc, 64'h80);
    check("b_no_store", DW'(out_valid), 64'd0);
    idle_in(); tick();
    check("b_pulse_end", DW'(redirect), 64'd0);

    // Both branch bits set behaves as B even with zero clear
    send_br(1'b1, 1'b1, 1'b0, 64'h90); tick();
    check("both_redirect", DW'(redirect), 64'd1);
    check("both_pc", redirect_pc, 64'h90);
    idle_in(); tick();

    // Reset while holding two entries
    out_ready = 1'b0;
    send_alu(64'h11); tick();
    send_alu(64'h22); tick();
    check("two_in_ready", DW'(in_ready), 64'd0);
    idle_in(); rst = 1'b1; tick(); rst = 1'b0;
    check("rst2_out_valid", DW'(out_valid), 64'd0);
    check("rst2_in_ready", DW'(in_ready), 64'd1);
    check("rst2_out_result", out_result, 64'd0);
    check("rst2_out_rd", DW'(out_rd), 64'd0);
    check("rst2_redirect_pc", redirect_pc, 64'd0);
    out_ready = 1'b1; tick();
    check("rst2_skid_gone", DW'(out_valid), 64'd0);

    // Reset with a redirect pending, one entry stored
    out_ready = 1'b0;
    send_alu(64'h33); tick();
    send_br(1'b0, 1'b1, 1'b0, 64'hC0); tick();
    check("pend_redirect", DW'(redirect), 64'd1);
    check("pend_kept_entry", out_result, 64'h33);
    idle_in(); rst = 1'b1; tick(); rst = 1'b0;
    check("rst3_redirect", DW'(redirect), 64'd0);
    check("rst3_redirect_pc", redirect_pc, 64'd0);
    check("rst3_out_valid", DW'(out_valid), 64'd0);
    check("rst3_out_result", out_result, 64'd0);

    // STUR payload
    out_ready = 1'b1;
    idle_in();
    in_valid = 1'b1; alu_result = 64'h100; store_data = 64'hDEAD; mem_write = 1'b1; rd = 5'd7;
    tick();
    check("stur_valid", DW'(out_valid), 64'd1);
    check("stur_result", out_result, 64'h100);
    check("stur_store", out_store_data, 64'hDEAD);
    check("stur_mem_write", DW'(out_mem_write), 64'd1);
    check("stur_reg_write", DW'(out_reg_write), 64'd0);
    check("stur_rd", DW'(out_rd), 64'd7);

    // LDUR payload with zero flag
    idle_in();
    in_valid = 1'b1; alu_result = 64'h0; alu_zero = 1'b1; mem_read = 1'b1;
    reg_write = 1'b1; mem_to_reg = 1'b1; rd = 5'd3;
    tick();
    check("ldur_mem_read", DW'(out_mem_read), 64'd1);
    check("ldur_mem_to_reg", DW'(out_mem_to_reg), 64'd1);
    check("ldur_zero", DW'(out_zero), 64'd1);
    check("ldur_mem_write", DW'(out_mem_write), 64'd0);
    idle_in(); tick();
    check("final_drain", DW'(out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
